// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller among NUM_REQ pipeline requesters.
// Optional ACCESS watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [18*NUM_REQ-1:0] req_addr,
    input  logic [16*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [15:0]           resp_rdata,
    output logic                  ctrl_read_en,
    output logic                  ctrl_wr_en,
    output logic [17:0]           ctrl_address,
    output logic [15:0]           ctrl_wr_data,
    input  logic                  ctrl_read_valid,
    input  logic                  ctrl_wr_valid,
    input  logic [15:0]           ctrl_read_data,
    output logic                  busy,
    output logic                  timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_params
        $error("sram_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  last_winner, winner_next;
    logic        have_winner;
    logic        first_q, we_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic        done, expire;
    logic [NUM_REQ-1:0] winner_onehot;

    // Search starts one past the previous winner so a held request cannot starve others.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner_next = last_winner;
        have_winner = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_winner) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!have_winner && ((req & (NUM_REQ'(1) << idx)) != '0)) begin
                have_winner = 1'b1;
                winner_next = 2'(idx);
            end
        end
    end

    assign winner_onehot = NUM_REQ'(1) << last_winner;
    assign done = (state == ACCESS) && (we_q ? ctrl_wr_valid : ctrl_read_valid);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (have_winner) state_next = ACCESS;
            ACCESS:  if (done || expire) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= 2'(NUM_REQ - 1);
            first_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            first_q <= (state == IDLE) && have_winner;
            if (state == IDLE && have_winner) begin
                last_winner <= winner_next;
                we_q        <= (req_we & (NUM_REQ'(1) << winner_next)) != '0;
                addr_q      <= 18'(req_addr >> (18 * winner_next));
                wdata_q     <= 16'(req_wdata >> (16 * winner_next));
                rdata_q     <= '0;
            end else if (done && !we_q) begin
                rdata_q <= ctrl_read_data;
            end
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;

    assign expire      = (state == ACCESS) && !done && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == ACCESS) ? wd_cnt + 8'd1 : 8'd0;
            if (expire) err_q <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        gnt          = '0;
        resp_valid   = '0;
        resp_rdata   = '0;
        ctrl_read_en = 1'b0;
        ctrl_wr_en   = 1'b0;
        ctrl_address = '0;
        ctrl_wr_data = '0;
        busy         = (state != IDLE);
        case (state)
            ACCESS: begin
                ctrl_read_en = !we_q;
                ctrl_wr_en   = we_q;
                ctrl_address = addr_q;
                ctrl_wr_data = wdata_q;
                if (first_q) gnt = winner_onehot;
            end
            RESP: begin
                resp_valid = winner_onehot;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, scoreboard of responses, corner-case sequences.
module tb_sram_arbiter;
    localparam int N = 2;

    logic          clk, rst;
    logic [N-1:0]  req, req_we;
    logic [18*N-1:0] req_addr;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]  gnt, resp_valid;
    logic [15:0]   resp_rdata;
    logic          ctrl_read_en, ctrl_wr_en;
    logic [17:0]   ctrl_address;
    logic [15:0]   ctrl_wr_data;
    logic          ctrl_read_valid, ctrl_wr_valid;
    logic [15:0]   ctrl_read_data;
    logic          busy, timeout_err;

    sram_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ctrl_read_en(ctrl_read_en), .ctrl_wr_en(ctrl_wr_en), .ctrl_address(ctrl_address),
        .ctrl_wr_data(ctrl_wr_data), .ctrl_read_valid(ctrl_read_valid),
        .ctrl_wr_valid(ctrl_wr_valid), .ctrl_read_data(ctrl_read_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    we;
        logic [18*N-1:0] addr;
        logic [16*N-1:0] wdata;
        int              k;
        logic [15:0]     rdata;
        int              exp_w;
    } vec_t;

    typedef struct {
        int          w;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every resp_valid must match the oldest outstanding grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst && resp_valid != '0) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("resp_valid", 64'(resp_valid), 64'(1 << e.w));
                check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
            end
        end else if (resp_rdata != '0) begin
            check("rdata_outside_resp", 64'(resp_rdata), 64'(0));
        end
    end

    task automatic do_access(input vec_t v, input bit hold);
        bit          ok;
        logic        exp_we;
        logic [17:0] ea;
        logic [15:0] ed;
        req = v.req; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (gnt != '0) ok = 1'b1;
        end
        if (!ok) begin
            check("gnt_wait", 64'(0), 64'(1));
            req = '0;
            return;
        end
        exp_we = 1'(v.we >> v.exp_w);
        ea     = 18'(v.addr >> (18 * v.exp_w));
        ed     = 16'(v.wdata >> (16 * v.exp_w));
        check("gnt", 64'(gnt), 64'(1 << v.exp_w));
        check("rd_en", 64'(ctrl_read_en), 64'(!exp_we));
        check("wr_en", 64'(ctrl_wr_en), 64'(exp_we));
        check("addr", 64'(ctrl_address), 64'(ea));
        check("wdata", 64'(ctrl_wr_data), 64'(ed));
        sb.push_back('{v.exp_w, exp_we ? 16'h0000 : v.rdata});
        if (!hold) begin
            // Fields are don't-care after gnt; scramble them to prove they were latched.
            req = '0; req_we = ~v.we; req_addr = '1; req_wdata = '1;
        end
        for (int j = 0; j < v.k; j++) begin
            if (exp_we) ctrl_read_valid = 1'b1;
            else        ctrl_wr_valid   = 1'b1;
            @(negedge clk);
            ctrl_read_valid = 1'b0; ctrl_wr_valid = 1'b0;
            check("hold_en", 64'(exp_we ? ctrl_wr_en : ctrl_read_en), 64'(1));
            check("hold_addr", 64'(ctrl_address), 64'(ea));
            check("gnt_once", 64'(gnt), 64'(0));
        end
        if (exp_we) ctrl_wr_valid = 1'b1;
        else begin
            ctrl_read_valid = 1'b1;
            ctrl_read_data  = v.rdata;
        end
        @(negedge clk);
        ctrl_read_valid = 1'b0; ctrl_wr_valid = 1'b0; ctrl_read_data = 16'hDEAD;
        check("resp_en_low", 64'({ctrl_read_en, ctrl_wr_en}), 64'(0));
        check("resp_addr_zero", 64'(ctrl_address), 64'(0));
        check("busy_resp", 64'(busy), 64'(1));
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));
        check("idle_no_resp", 64'(resp_valid), 64'(0));
    endtask

    initial begin
        vec_t v;
        bit   ok;
        int   en_cycles;
        rst = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        ctrl_read_valid = 1'b0; ctrl_wr_valid = 1'b0; ctrl_read_data = '0;

        vecs[0] = '{2'b01, 2'b00, {18'h00000, 18'h00123}, {16'h0000, 16'h0000}, 2, 16'hBEEF, 0};
        vecs[1] = '{2'b10, 2'b10, {18'h3FFFF, 18'h00000}, {16'hA5A5, 16'h0000}, 0, 16'h0000, 1};
        vecs[2] = '{2'b11, 2'b01, {18'h2AAAA, 18'h15555}, {16'hCAFE, 16'h0BAD}, 1, 16'h0000, 0};
        vecs[3] = '{2'b11, 2'b01, {18'h2AAAA, 18'h15555}, {16'hCAFE, 16'h0BAD}, 3, 16'h5A5A, 1};
        vecs[4] = '{2'b01, 2'b00, {18'h00000, 18'h00001}, {16'h0000, 16'h7777}, 0, 16'h8001, 0};
        vecs[5] = '{2'b10, 2'b10, {18'h12345, 18'h00000}, {16'hFFFF, 16'h0000}, 1, 16'h0000, 1};

        #1;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_resp", 64'({resp_valid, resp_rdata}), 64'(0));
        check("rst_ctrl", 64'({ctrl_read_en, ctrl_wr_en, ctrl_address, ctrl_wr_data}), 64'(0));
        check("rst_busy_err", 64'({busy, timeout_err}), 64'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) do_access(vecs[i], 1'b0);

        // Stray completions while idle must be ignored.
        ctrl_wr_valid = 1'b1; ctrl_read_valid = 1'b1;
        @(negedge clk);
        ctrl_wr_valid = 1'b0; ctrl_read_valid = 1'b0;
        check("stray_busy", 64'(busy), 64'(0));
        check("stray_resp", 64'(resp_valid), 64'(0));
        v = '{2'b01, 2'b00, {18'h00000, 18'h0ABCD}, {16'h0000, 16'h0000}, 1, 16'h1357, 0};
        do_access(v, 1'b0);

        // Reset in the middle of ACCESS: outputs drop at once, no response follows.
        req = 2'b01; req_we = 2'b00; req_addr = {18'h0, 18'h0BEEF};
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (gnt != '0) ok = 1'b1;
        end
        check("mid_rst_gnt", 64'(gnt), 64'(1));
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_en", 64'({ctrl_read_en, ctrl_wr_en}), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_gnt_resp", 64'({gnt, resp_valid}), 64'(0));
        check("mid_rst_addr", 64'(ctrl_address), 64'(0));
        req = '0;
        @(negedge clk);
        rst = 1'b1;

        // Contention with both requests held: strict alternation starting at 0.
        for (int i = 0; i < 4; i++) begin
            v = '{2'b11, 2'b10, {18'h00020, 18'h00010}, {16'h1111, 16'h2222}, 1, 16'h0F0F, i % 2};
            do_access(v, 1'b1);
        end
        req = '0;

`ifdef SRAM_ARB_TIMEOUT_EN
        req = 2'b01; req_we = 2'b00; req_addr = {18'h0, 18'h00042};
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (gnt != '0) ok = 1'b1;
        end
        check("wd_gnt", 64'(gnt), 64'(1));
        sb.push_back('{0, 16'h0000});
        req = '0;
        en_cycles = 1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (ctrl_read_en) en_cycles++;
            if (resp_valid != '0) ok = 1'b1;
        end
        check("wd_resp_seen", 64'(ok), 64'(1));
        check("wd_access_cycles", 64'(en_cycles), 64'(4));
        check("wd_err_set", 64'(timeout_err), 64'(1));
        v = '{2'b10, 2'b00, {18'h00077, 18'h00000}, {16'h0000, 16'h0000}, 0, 16'h4242, 1};
        do_access(v, 1'b0);
        check("wd_err_sticky", 64'(timeout_err), 64'(1));
`else
        en_cycles = 0;
        check("no_wd_err", 64'(timeout_err), 64'(0));
`endif

        @(negedge clk); @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single off-chip SRAM controller between up to NUM_REQ image-pipeline requesters, for example a camera write port and a display read port. Round-robin arbitration selects one requester at a time. The block latches that requester's address and data and holds the controller's read or write enable until the controller reports valid. It then returns a one-cycle response to the winner. It sits between the pipeline masters and the SRAM controller, which remains the only block driving the SRAM pins.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- TIMEOUT_CYCLES, 64, watchdog limit for the ACCESS state; legal range 2..255; used only with the watchdog macro.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  18*NUM_REQ  word address; requester i uses bits [18*i +: 18].
- req_wdata  in  16*NUM_REQ  write data; requester i uses bits [16*i +: 16].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse marking acceptance.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_rdata  out  16  read data; valid only while resp_valid is high.
- ctrl_read_en, ctrl_wr_en  out  1  enables to the SRAM controller.
- ctrl_address  out  18  address to the SRAM controller.
- ctrl_wr_data  out  16  write data to the SRAM controller.
- ctrl_read_valid, ctrl_wr_valid  in  1  controller completion flags.
- ctrl_read_data  in  16  controller read data.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky watchdog error flag.

## Operation
- States:
  - IDLE: if req is nonzero, pick the winner, latch its we/addr/wdata into internal registers, record it as last_winner, and go to ACCESS.
  - ACCESS: assert ctrl_read_en (we=0) or ctrl_wr_en (we=1) from the registers; when the matching ctrl_*_valid is sampled high, go to RESP.
  - RESP: drop both enables, pulse resp_valid[winner], go to IDLE.
- Round robin:
  - The search starts at (last_winner+1) mod NUM_REQ and takes the first set req bit.
  - last_winner resets to NUM_REQ-1, so requester 0 wins first.
  - A requester that stays asserted cannot starve the others.
- Requester protocol:
  - Hold req and all fields stable until gnt.
  - Fields are ignored after gnt.
  - req still high in the cycle after resp_valid counts as a new request.
- Read data: on a read, ctrl_read_data is captured at the edge where ctrl_read_valid is sampled. It is driven on resp_rdata during RESP and is 0 otherwise.
- Writes: resp_valid signals completion and resp_rdata stays 0.
- Unmatched valid: the opposite-type ctrl_*_valid in ACCESS is ignored. A ctrl_*_valid outside ACCESS is ignored.
- Simultaneous events: req arriving during ACCESS or RESP waits for IDLE; no preemption.
- Reset values: all outputs are 0, state is IDLE, latched registers are 0, timeout_err is 0.
- Reset mid-access: the enables drop asynchronously, and no gnt or resp is issued for the aborted access.

## Timing
- Cycle-level sequence for an uncontended request:
  - req sampled at edge t0.
  - ACCESS from t0; gnt and the ctrl enable are high in cycle t0..t1.
  - ctrl_*_valid sampled high at edge t1+k (k≥0).
  - RESP cycle follows, carrying resp_valid.
  - IDLE for one cycle.
- Minimum cost is 3 cycles per access with a zero-wait controller.
- gnt is high exactly during the first ACCESS cycle.
- ctrl_address and ctrl_wr_data are stable for the whole ACCESS state and 0 outside it.
- All outputs are registered or decoded from state; there is no combinational path from req to gnt.

## Configuration
- SRAM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in ACCESS.
  - If it reaches TIMEOUT_CYCLES without a matching valid, the block drops the enables and goes to RESP.
  - In that RESP it pulses resp_valid[winner] with resp_rdata=0 and sets timeout_err.
  - timeout_err stays set until reset.
- SRAM_ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely, timeout_err is tied 0, and TIMEOUT_CYCLES has no effect.

## Test plan
- Single read: req[0]=1, we=0, addr=18'h00123; controller returns 16'hBEEF after 2 cycles. Expect gnt[0] pulse, ctrl_read_en high 3 cycles, then resp_valid[0] with resp_rdata=16'hBEEF.
- Single write: req[1]=1, we=1, addr=18'h3FFFF, wdata=16'hA5A5. Expect ctrl_wr_en with those values on ctrl_address/ctrl_wr_data until ctrl_wr_valid, then resp_valid[1], resp_rdata=0.
- Contention: req=2'b11 held continuously for 4 accesses. Expect grant order 0,1,0,1 with every resp_valid following its own gnt.
- Mid-access reset: assert rst low during ACCESS. Expect enables, busy, gnt and resp_valid to go 0 immediately; after release the first request is granted to requester 0.
- Late valid: ctrl_wr_valid pulses while idle, then a read request is made. Expect the stray pulse ignored and the read to complete normally.
- Watchdog (macro defined, TIMEOUT_CYCLES=4): the controller never returns valid. Expect resp_valid after the counter reaches 4, resp_rdata=0, timeout_err=1 and staying 1 across later accesses.
